// File: rtl/btn_cond_pkg.sv
// Shared constants, register map and helpers for the push-button conditioner.
// Repeat build option: BTN_CONDITIONER_REPEAT_EN (see btn_debounce).
package btn_cond_pkg;

  localparam int unsigned N_BTN_DEF           = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int unsigned REPEAT_DELAY_DEF    = 50000000;
  localparam int unsigned REPEAT_RATE_DEF     = 10000000;

  localparam logic [31:0] BTN_LEVEL_OFS = 32'h0;
  localparam logic [31:0] BTN_EVT_OFS   = 32'h4;

  typedef enum logic {
    REG_LEVEL = 1'b0,
    REG_EVT   = 1'b1
  } reg_sel_e;

  // Only address bit 2 distinguishes the two registers.
  function automatic reg_sel_e decode_reg(input logic addr_bit2);
    if ((addr_bit2 == BTN_EVT_OFS[2]) && (BTN_EVT_OFS[2] != BTN_LEVEL_OFS[2]))
      return REG_EVT;
    return REG_LEVEL;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchroniser, stability counter, edge pulses.
// With BTN_CONDITIONER_REPEAT_EN defined, a held button also emits auto-repeat presses.
module btn_debounce
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE     = REPEAT_RATE_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          rpt_hit;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // level_q trails stable_q by one cycle so the level and its pulse appear together.
  always_comb begin
    press_d   = (stable_q & ~level_q) | rpt_hit;
    release_d = ~stable_q & level_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      level_q   <= stable_q;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef BTN_CONDITIONER_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW      = cnt_width(RPT_MAX);
  localparam logic [RW-1:0] RPT_DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_first_q, rpt_first_d;

  // First repeat waits REPEAT_DELAY after acceptance, later ones REPEAT_RATE apart.
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_first_d = 1'b1;
    rpt_hit     = 1'b0;
    if (level_q && stable_q) begin
      rpt_first_d = rpt_first_q;
      rpt_cnt_d   = rpt_cnt_q + 1'b1;
      if (rpt_cnt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_RATE_LAST)) begin
        rpt_hit     = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
  assign rpt_hit    = 1'b0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioning block: per-button debounce plus sticky press flags on a slave port.
// Auto-repeat is built in when BTN_CONDITIONER_REPEAT_EN is defined.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned N_BTN           = N_BTN_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE     = REPEAT_RATE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  input  logic             bus_valid,
  output logic             bus_ready,
  input  logic [3:0]       bus_wstrb,
  input  logic [31:0]      bus_addr,
  output logic [31:0]      bus_rdata
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_debounce (
      .clk_i     (clk),
      .rst_i     (reset),
      .raw_i     (btn_raw[g]),
      .level_o   (btn_level[g]),
      .press_o   (btn_press[g]),
      .release_o (btn_release[g])
    );
  end

  logic [N_BTN-1:0] evt_q, evt_d, clr_bits;
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             req;
  logic             is_write;
  reg_sel_e         sel;

  logic unused_bus;
  assign unused_bus = ^{bus_addr[31:3], bus_addr[1:0]};

  // A press landing in the same cycle as the read-clear is OR-ed back in and survives.
  always_comb begin
    req      = bus_valid && !ready_q;
    is_write = |bus_wstrb;
    sel      = decode_reg(bus_addr[2]);
    ready_d  = req;
    rdata_d  = '0;
    clr_bits = '0;
    if (req) begin
      if (sel == REG_EVT) begin
        rdata_d[N_BTN-1:0] = evt_q;
        if (!is_write) begin
          clr_bits = evt_q;
        end
      end else begin
        rdata_d[N_BTN-1:0] = btn_level;
      end
    end
    evt_d = (evt_q & ~clr_bits) | btn_press;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      evt_q   <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      evt_q   <= evt_d;
    end
  end

  assign bus_ready = ready_q;
  assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timing.
module tb_btn_conditioner;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release;
  logic         bus_valid;
  logic         bus_ready;
  logic [3:0]   bus_wstrb;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  btn_conditioner #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (8),
    .REPEAT_DELAY    (40),
    .REPEAT_RATE     (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_wstrb   (bus_wstrb),
    .bus_addr    (bus_addr),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] evt;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One request; returns the data seen while bus_ready is high.
  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb, output logic [31:0] data);
    @(negedge clk);
    bus_valid = 1'b1;
    bus_addr  = addr;
    bus_wstrb = strb;
    @(posedge clk);
    #1;
    check("bus_ready ack", 32'(bus_ready), 32'd1);
    data      = bus_rdata;
    bus_valid = 1'b0;
    bus_wstrb = 4'h0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    int first_k, pulses, mism;
    logic got;

    vecs[0] = '{4'b0001, 4'b0001, 4'b0001};
    vecs[1] = '{4'b0011, 4'b0011, 4'b0010};
    vecs[2] = '{4'b0010, 4'b0010, 4'b0000};
    vecs[3] = '{4'b1100, 4'b1100, 4'b1100};
    vecs[4] = '{4'b0000, 4'b0000, 4'b0000};
    vecs[5] = '{4'b1111, 4'b1111, 4'b1111};
    vecs[6] = '{4'b0000, 4'b0000, 4'b0000};

    reset     = 1'b1;
    btn_raw   = '0;
    bus_valid = 1'b0;
    bus_wstrb = 4'h0;
    bus_addr  = '0;
    cycles(3);
    check("reset btn_level", 32'(btn_level), 32'h0);
    check("reset btn_press", 32'(btn_press), 32'h0);
    check("reset btn_release", 32'(btn_release), 32'h0);
    check("reset bus_ready", 32'(bus_ready), 32'h0);
    check("reset bus_rdata", bus_rdata, 32'h0);
    reset = 1'b0;
    cycles(2);

    // Clean press: pulse 11 cycles after the raw edge.
    btn_raw[0] = 1'b1;
    first_k = -1; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      cycles(1);
      if (btn_press[0]) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    check("press latency", 32'(first_k), 32'd11);
    check("press pulse count", 32'(pulses), 32'd1);
    check("level after press", 32'(btn_level), 32'h1);
    btn_raw[0] = 1'b0;
    first_k = -1; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      cycles(1);
      if (btn_release[0]) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    check("release latency", 32'(first_k), 32'd11);
    check("release pulse count", 32'(pulses), 32'd1);
    check("level after release", 32'(btn_level), 32'h0);
    bus_xfer(32'h4, 4'h0, rd);
    check("evt after clean press", rd, 32'h1);

    // Bounce on button 1: toggles every 3 cycles, then settles high.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      btn_raw[1] = ~btn_raw[1];
      for (int c = 0; c < 3; c++) begin
        cycles(1);
        if (btn_press[1] || btn_level[1]) pulses++;
      end
    end
    check("bounce no press", 32'(pulses), 32'd0);
    btn_raw[1] = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      cycles(1);
      if (btn_press[1]) pulses++;
    end
    check("bounce single press", 32'(pulses), 32'd1);
    btn_raw[1] = 1'b0;
    cycles(13);
    bus_xfer(32'h4, 4'h0, rd);
    check("evt after bounce", rd, 32'h2);

    // Table of steady input patterns.
    for (int v = 0; v < 7; v++) begin
      btn_raw = vecs[v].raw;
      cycles(13);
      check($sformatf("vec%0d btn_level", v), 32'(btn_level), 32'(vecs[v].level));
      bus_xfer(32'h0, 4'h0, rd);
      check($sformatf("vec%0d level reg", v), rd, 32'(vecs[v].level));
      bus_xfer(32'h4, 4'h0, rd);
      check($sformatf("vec%0d evt reg", v), rd, 32'(vecs[v].evt));
    end

    // Event read clears.
    btn_raw[2] = 1'b1;
    cycles(13);
    btn_raw[2] = 1'b0;
    cycles(13);
    bus_xfer(32'h4, 4'h0, rd);
    check("evt read btn2", rd, 32'h4);
    bus_xfer(32'h4, 4'h0, rd);
    check("evt reread cleared", rd, 32'h0);

    // A write to the event register must not clear it.
    btn_raw[0] = 1'b1;
    cycles(13);
    btn_raw[0] = 1'b0;
    cycles(13);
    bus_xfer(32'h4, 4'hF, rd);
    check("write ack data", rd, 32'h1);

    // Press of button 3 coincides with the read-clear.
    btn_raw[3] = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("coincident press present", 32'(btn_press[3]), 32'd1);
    bus_valid = 1'b1;
    bus_addr  = 32'h4;
    @(posedge clk);
    #1;
    check("coincident ready", 32'(bus_ready), 32'd1);
    check("coincident rdata", bus_rdata, 32'h1);
    bus_valid = 1'b0;
    btn_raw[3] = 1'b0;
    cycles(13);
    bus_xfer(32'h4, 4'h0, rd);
    check("evt survives clear", rd, 32'h8);

    // Held request: acknowledged at t+1 and t+3 only.
    @(negedge clk);
    bus_valid = 1'b1;
    bus_addr  = 32'h0;
    cycles(1);
    check("b2b ready t+1", 32'(bus_ready), 32'd1);
    cycles(1);
    check("b2b ready t+2", 32'(bus_ready), 32'd0);
    cycles(1);
    check("b2b ready t+3", 32'(bus_ready), 32'd1);
    bus_valid = 1'b0;
    cycles(1);
    check("b2b ready idle", 32'(bus_ready), 32'd0);

    // Long hold of button 0.
    btn_raw[0] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      cycles(1);
      if (btn_press[0]) got = 1'b1;
    end
    check("hold accepted", 32'(got), 32'd1);
    pulses = 0; mism = 0;
    for (int c = 1; c < 100; c++) begin
      logic exp_p;
      cycles(1);
`ifdef BTN_CONDITIONER_REPEAT_EN
      exp_p = (c >= 40) && ((c - 40) % 10 == 0);
`else
      exp_p = 1'b0;
`endif
      if (btn_press[0]) pulses++;
      if (btn_press[0] !== exp_p) mism++;
    end
`ifdef BTN_CONDITIONER_REPEAT_EN
    check("repeat pulse count", 32'(pulses), 32'd6);
`else
    check("repeat pulse count", 32'(pulses), 32'd0);
`endif
    check("repeat pulse timing", 32'(mism), 32'd0);
    btn_raw[0] = 1'b0;
    cycles(13);
    bus_xfer(32'h4, 4'h0, rd);
    check("evt after hold", rd, 32'h1);

    // Reset while a request is pending.
    btn_raw[1] = 1'b1;
    cycles(13);
    check("pre-reset level", 32'(btn_level), 32'h2);
    @(negedge clk);
    bus_valid = 1'b1;
    bus_addr  = 32'h4;
    reset     = 1'b1;
    cycles(1);
    check("reset drops ready", 32'(bus_ready), 32'd0);
    check("reset clears level", 32'(btn_level), 32'h0);
    check("reset clears rdata", bus_rdata, 32'h0);
    btn_raw = '0;
    cycles(1);
    check("reset holds ready low", 32'(bus_ready), 32'd0);
    reset     = 1'b0;
    bus_valid = 1'b0;
    cycles(2);
    bus_xfer(32'h4, 4'h0, rd);
    check("evt cleared by reset", rd, 32'h0);
    check("level after reset", 32'(btn_level), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
